// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared constants, state type and helpers for the Ethernet transmit frame path
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

    localparam int ETH_PRE_LEN = 7;
    localparam int ETH_HDR_LEN = 14;
    localparam int ETH_FCS_LEN = 4;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        HDR,
        PAY,
        FCS,
        IFG
    } eth_tx_state_t;

    // Header byte idx (0..13) of DST_MAC, SRC_MAC, ETHERTYPE, each sent MSB byte first.
    function automatic logic [7:0] eth_hdr_byte(
        input logic [47:0] dst,
        input logic [47:0] src,
        input logic [15:0] etype,
        input logic [3:0]  idx
    );
        logic [111:0] hdr;
        hdr = {dst, src, etype} << {idx, 3'b000};
        return hdr[111:104];
    endfunction

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - combinational byte-wide CRC-32 next state, MSB-aligned register, LSB-first data
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] crc_v;

    // Eight serial steps unrolled; data bit 0 enters first, matching wire order.
    always_comb begin
        crc_v = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_v[31] ^ data[i]) begin
                crc_v = {crc_v[30:0], 1'b0} ^ CRC32_POLY;
            end else begin
                crc_v = {crc_v[30:0], 1'b0};
            end
        end
        crc_out = crc_v;
    end

endmodule

// File: rtl/eth_tx_frame.sv
// rtl/eth_tx_frame.sv - generates one complete Ethernet frame per start request, one byte per clk125
module eth_tx_frame
    import eth_pkg::*;
#(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int          PAYLOAD_LEN = 46,
    parameter int          IFG_BYTES   = 12
) (
    input  logic        clk125,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        tx_en,
    output logic        tx_er,
    output logic [7:0]  tx_data,
    output logic [15:0] frame_cnt
);

    if (PAYLOAD_LEN < 46 || PAYLOAD_LEN > 1500) begin : g_bad_payload_len
        $error("eth_tx_frame: PAYLOAD_LEN must be within 46..1500");
    end
    if (IFG_BYTES < 12) begin : g_bad_ifg
        $error("eth_tx_frame: IFG_BYTES must be at least 12");
    end

    localparam logic [10:0] PRE_LAST = 11'(ETH_PRE_LEN - 1);
    localparam logic [10:0] HDR_LAST = 11'(ETH_HDR_LEN - 1);
    localparam logic [10:0] PAY_LAST = 11'(PAYLOAD_LEN - 1);
    localparam logic [10:0] FCS_LAST = 11'(ETH_FCS_LEN - 1);
    // The IDLE cycle that follows IFG is itself the last gap cycle, so held
    // start yields exactly IFG_BYTES idle cycles between frames.
    localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 2);

    eth_tx_state_t state_q, state_d;
    logic [10:0]   cnt_q, cnt_d;
    logic [31:0]   crc_q, crc_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          tx_en_q, tx_en_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          busy_q, busy_d;

    logic [7:0]    byte_d;
    logic [31:0]   crc_next;
    logic [31:0]   fcs_word;

    crc32_d8 u_crc32_d8 (
        .crc_in  (crc_q),
        .data    (byte_d),
        .crc_out (crc_next)
    );

    assign fcs_word = ~crc_q;

    // Next state and byte counter; the counter restarts at every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 11'd1;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = PRE;
                end
            end
            PRE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = SFD;
                    cnt_d   = '0;
                end
            end
            SFD: begin
                state_d = HDR;
                cnt_d   = '0;
            end
            HDR: begin
                if (cnt_q == HDR_LAST) begin
                    state_d = PAY;
                    cnt_d   = '0;
                end
            end
            PAY: begin
                if (cnt_q == PAY_LAST) begin
                    state_d = FCS;
                    cnt_d   = '0;
                end
            end
            FCS: begin
                if (cnt_q == FCS_LAST) begin
                    state_d = IFG;
                    cnt_d   = '0;
                end
            end
            IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Byte for the state being entered, plus CRC, frame counter and output flags.
    always_comb begin
        byte_d = 8'h00;
        unique case (state_d)
            PRE: byte_d = ETH_PREAMBLE;
            SFD: byte_d = ETH_SFD;
            HDR: byte_d = eth_hdr_byte(DST_MAC, SRC_MAC, ETHERTYPE, cnt_d[3:0]);
            PAY: byte_d = cnt_d[7:0] ^ frame_cnt_q[7:0];
            FCS: begin
                // Complemented register is bit-reversed onto the wire, x^31 term first.
                unique case (cnt_d[1:0])
                    2'd0:    byte_d = bitrev8(fcs_word[31:24]);
                    2'd1:    byte_d = bitrev8(fcs_word[23:16]);
                    2'd2:    byte_d = bitrev8(fcs_word[15:8]);
                    default: byte_d = bitrev8(fcs_word[7:0]);
                endcase
            end
            default: byte_d = 8'h00;
        endcase

        crc_d = crc_q;
        if (state_d == SFD) begin
            crc_d = CRC32_INIT;
        end else if (state_d == HDR || state_d == PAY) begin
            crc_d = crc_next;
        end

        frame_cnt_d = frame_cnt_q;
        if (state_d == FCS && cnt_d == FCS_LAST) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        tx_en_d   = (state_d == PRE) || (state_d == SFD) || (state_d == HDR) ||
                    (state_d == PAY) || (state_d == FCS);
        tx_data_d = tx_en_d ? byte_d : 8'h00;
        busy_d    = (state_d != IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk125) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            crc_q       <= CRC32_INIT;
            frame_cnt_q <= '0;
            tx_en_q     <= 1'b0;
            tx_data_q   <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            frame_cnt_q <= frame_cnt_d;
            tx_en_q     <= tx_en_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign tx_en     = tx_en_q;
    assign tx_er     = 1'b0;
    assign tx_data   = tx_data_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_eth_tx_frame.sv
// tb/tb_eth_tx_frame.sv - directed scoreboard bench for eth_tx_frame
module tb_eth_tx_frame;

    localparam int IFG = 12;
    localparam int FRAME_BYTES = 8 + 14 + 46 + 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        tx_en;
    logic        tx_er;
    logic [7:0]  tx_data;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] cap[$];
    logic [7:0] last_frame[$];
    int         runlen_q[$];
    int         gap_q[$];
    logic [7:0] pay0_q[$];
    int         frames_done = 0;
    int         en_run = 0;
    int         gap_run = 0;
    bit         prev_en = 0;
    bit         have_prev = 0;
    bit         in_gap = 0;
    bit         mon_on = 0;
    logic [31:0] exp_fcs;

    eth_tx_frame dut (
        .clk125    (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .tx_en     (tx_en),
        .tx_er     (tx_er),
        .tx_data   (tx_data),
        .frame_cnt (frame_cnt)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = v[31-k];
        return r;
    endfunction

    task automatic push_frame(input logic [7:0] fc);
        logic [111:0] hdr;
        logic [31:0]  c;
        logic [7:0]   b;
        hdr = {48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h88B5};
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 14; i++) begin
            b = hdr[111 - 8*i -: 8];
            exp_q.push_back(b);
            c = crc_upd(c, b);
        end
        for (int i = 0; i < 46; i++) begin
            b = 8'(i) ^ fc;
            exp_q.push_back(b);
            c = crc_upd(c, b);
        end
        exp_fcs = ~c;
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_fcs[8*i +: 8]);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        exp_q.delete();
        cap.delete();
        runlen_q.delete();
        gap_q.delete();
        pay0_q.delete();
        frames_done = 0;
        en_run = 0;
        gap_run = 0;
        prev_en = 0;
        have_prev = 0;
        in_gap = 0;
    endtask

    task automatic wait_frames(input int n, input int limit);
        int k;
        k = 0;
        while (frames_done < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        #1;
        chk("frames_done", 32'(frames_done), 32'(n));
    endtask

    task automatic check_residue(input string tag);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < last_frame.size(); i++) c = crc_upd(c, last_frame[i]);
        chk(tag, bitrev32(c), 32'hC704_DD7B);
    endtask

    // Scoreboard monitor: pops an expected byte for every tx_en cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("tx_er", {31'h0, tx_er}, 32'h0);
            if (tx_en === 1'b1) begin
                if (!prev_en) begin
                    if (have_prev) gap_q.push_back(gap_run);
                    cap.delete();
                    en_run = 0;
                    in_gap = 0;
                end
                chk("busy_in_frame", {31'h0, busy}, 32'h1);
                chk("exp_q_nonempty", 32'(exp_q.size() > 0), 32'h1);
                if (exp_q.size() > 0) chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
                cap.push_back(tx_data);
                en_run++;
                if (en_run == 23) pay0_q.push_back(tx_data);
                prev_en = 1;
            end else begin
                chk("tx_en_idle", {31'h0, tx_en}, 32'h0);
                chk("tx_data_idle", {24'h0, tx_data}, 32'h0);
                if (prev_en) begin
                    runlen_q.push_back(en_run);
                    last_frame = cap;
                    frames_done++;
                    in_gap = 1;
                    gap_run = 0;
                    have_prev = 1;
                end
                if (in_gap) begin
                    gap_run++;
                    if (gap_run == IFG - 1) chk("busy_last_ifg", {31'h0, busy}, 32'h1);
                    if (gap_run == IFG)     chk("busy_after_ifg", {31'h0, busy}, 32'h0);
                end
                prev_en = 0;
            end
        end
    end

    initial begin
        // 1. reset
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_en", {31'h0, tx_en}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_frame_cnt", {16'h0, frame_cnt}, 32'h0);
        chk("rst_tx_er", {31'h0, tx_er}, 32'h0);
        mon_on = 1;

        // 2/3. single frame
        tick(1);
        while (cyc < 10) tick(1);
        push_frame(8'h00);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        @(negedge clk);
        chk("latency_tx_en", {31'h0, tx_en}, 32'h1);
        chk("latency_byte", {24'h0, tx_data}, 32'h55);
        wait_frames(1, 200);
        chk("frame_len", 32'(runlen_q.size() > 0 ? runlen_q[0] : 0), 32'(FRAME_BYTES));
        check_residue("residue_1");
        chk("fcs_model", (last_frame.size() == FRAME_BYTES) ?
            {last_frame[71], last_frame[70], last_frame[69], last_frame[68]} : 32'h0, exp_fcs);
        chk("frame_cnt_1", {16'h0, frame_cnt}, 32'd1);
        tick(20);
        chk("exp_q_drained_1", 32'(exp_q.size()), 32'h0);

        // 4. start held high, three back-to-back frames
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        clear_mon();
        tick(2);
        push_frame(8'h00);
        push_frame(8'h01);
        push_frame(8'h02);
        start = 1'b1;
        begin
            int k;
            k = 0;
            while (!(frames_done >= 2 && tx_en === 1'b1) && k < 400) begin
                @(negedge clk);
                k++;
            end
        end
        tick(1);
        start = 1'b0;
        wait_frames(3, 200);
        tick(40);
        chk("gap_count", 32'(gap_q.size()), 32'd2);
        if (gap_q.size() == 2) begin
            chk("gap_0", 32'(gap_q[0]), 32'(IFG));
            chk("gap_1", 32'(gap_q[1]), 32'(IFG));
        end
        chk("pay0_count", 32'(pay0_q.size()), 32'd3);
        if (pay0_q.size() == 3) begin
            chk("pay0_f0", {24'h0, pay0_q[0]}, 32'h00);
            chk("pay0_f1", {24'h0, pay0_q[1]}, 32'h01);
            chk("pay0_f2", {24'h0, pay0_q[2]}, 32'h02);
        end
        chk("frame_cnt_3", {16'h0, frame_cnt}, 32'd3);
        check_residue("residue_3");

        // 5. start pulses during PRE, PAY and IFG are ignored
        clear_mon();
        push_frame(8'h03);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(36);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(37);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(60);
        chk("ignored_frames", 32'(frames_done), 32'd1);
        chk("frame_cnt_4", {16'h0, frame_cnt}, 32'd4);
        chk("exp_q_drained_5", 32'(exp_q.size()), 32'h0);

        // 6. reset at payload byte 20, then a clean frame
        clear_mon();
        push_frame(8'h04);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(42);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_tx_en", {31'h0, tx_en}, 32'h0);
        chk("abort_tx_data", {24'h0, tx_data}, 32'h0);
        chk("abort_frame_cnt", {16'h0, frame_cnt}, 32'h0);
        #1;
        clear_mon();
        tick(3);
        push_frame(8'h00);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_frames(1, 200);
        chk("frame_len_6", 32'(runlen_q.size() > 0 ? runlen_q[0] : 0), 32'(FRAME_BYTES));
        check_residue("residue_6");
        chk("frame_cnt_6", {16'h0, frame_cnt}, 32'd1);
        tick(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
